// File: rtl/mult_minmax_pkg.sv
// Shared state encoding and mode constants for the sequential multiply / min-max unit.
package mult_minmax_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_MIN = 1'b0;
   localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/mult_minmax_seq_mult.sv
// LSB-first shift-add multiplier: one partial product per step, done after N steps.
module shift_add_mult #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
   output logic [2*N-1:0] acc,
   output logic           done
);

   localparam int CW = $clog2(N);

   logic [2*N-1:0] a_sh_q, a_sh_d;
   logic [N-1:0]   b_q, b_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   // A is pre-shifted each step, so adding it equals adding (A << step).
   always_comb begin
      a_sh_d = a_sh_q;
      b_d    = b_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      if (load) begin
         a_sh_d = {{N{1'b0}}, a_in};
         b_d    = b_in;
         acc_d  = '0;
         cnt_d  = '0;
      end else if (step) begin
         if (b_q[0]) begin
            acc_d = acc_q + a_sh_q;
         end
         a_sh_d = a_sh_q << 1;
         b_d    = b_q >> 1;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh_q <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else begin
         a_sh_q <= a_sh_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
      end
   end

   assign acc  = acc_q;
   // High during the Nth step, so the controller can leave MULT on that same edge.
   assign done = step && !load && (cnt_q == CW'(N - 1));

endmodule

// File: rtl/mult_minmax_seq.sv
// K-pair sequential multiply with per-product saturation, reduced to the min or max
// together with a bound operand; start/ready handshake.
module mult_minmax_seq
   import mult_minmax_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           mode,
   input  logic [K*N-1:0] in_a,
   input  logic [K*N-1:0] in_b,
   input  logic [N-1:0]   in_c,
   output logic           busy,
   output logic           ready,
   output logic           overflow,
   output logic [N-1:0]   result
);

   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [K*N-1:0]   a_cap_q, a_cap_d;
   logic [K*N-1:0]   b_cap_q, b_cap_d;
   logic [N-1:0]     extreme_q, extreme_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             overflow_q, overflow_d;
   logic [N-1:0]     result_q, result_d;

   logic             mul_load, mul_step, mul_done;
   logic [N-1:0]     mul_a, mul_b;
   logic [2*N-1:0]   mul_acc;

   logic             hi_nz;
   logic [N-1:0]     sat;
   logic [N-1:0]     new_extreme;

   shift_add_mult #(.N(N)) u_mult (
      .clk   (clk),
      .reset (reset),
      .load  (mul_load),
      .step  (mul_step),
      .a_in  (mul_a),
      .b_in  (mul_b),
      .acc   (mul_acc),
      .done  (mul_done)
   );

   assign hi_nz = (mul_acc[2*N-1:N] != '0);
   assign sat   = hi_nz ? {N{1'b1}} : mul_acc[N-1:0];

   always_comb begin
      new_extreme = extreme_q;
      if (mode_q == MODE_MAX) begin
         if (sat > extreme_q) new_extreme = sat;
      end else begin
         if (sat < extreme_q) new_extreme = sat;
      end
   end

   // Pending pairs are kept packed and shifted down, so the next pair is always at the LSBs.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      a_cap_d    = a_cap_q;
      b_cap_d    = b_cap_q;
      extreme_d  = extreme_q;
      idx_d      = idx_q;
      ovf_acc_d  = ovf_acc_q;
      busy_d     = busy_q;
      ready_d    = ready_q;
      overflow_d = overflow_q;
      result_d   = result_q;
      mul_load   = 1'b0;
      mul_step   = 1'b0;
      mul_a      = a_cap_q[N-1:0];
      mul_b      = b_cap_q[N-1:0];

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mode_d    = mode;
               a_cap_d   = in_a >> N;
               b_cap_d   = in_b >> N;
               extreme_d = in_c;
               idx_d     = '0;
               ovf_acc_d = 1'b0;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
               mul_load  = 1'b1;
               mul_a     = in_a[N-1:0];
               mul_b     = in_b[N-1:0];
               state_d   = MULT;
            end
         end
         MULT: begin
            mul_step = 1'b1;
            if (mul_done) state_d = CMP;
         end
         CMP: begin
            extreme_d = new_extreme;
            ovf_acc_d = ovf_acc_q | hi_nz;
            if (idx_q == IDX_W'(K - 1)) begin
               result_d   = new_extreme;
               overflow_d = ovf_acc_q | hi_nz;
               ready_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = DONE;
            end else begin
               idx_d    = idx_q + 1'b1;
               mul_load = 1'b1;
               a_cap_d  = a_cap_q >> N;
               b_cap_d  = b_cap_q >> N;
               state_d  = MULT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         mode_q     <= MODE_MIN;
         a_cap_q    <= '0;
         b_cap_q    <= '0;
         extreme_q  <= '0;
         idx_q      <= '0;
         ovf_acc_q  <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         overflow_q <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         a_cap_q    <= a_cap_d;
         b_cap_q    <= b_cap_d;
         extreme_q  <= extreme_d;
         idx_q      <= idx_d;
         ovf_acc_q  <= ovf_acc_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         overflow_q <= overflow_d;
         result_q   <= result_d;
      end
   end

   assign busy     = busy_q;
   assign ready    = ready_q;
   assign overflow = overflow_q;
   assign result   = result_q;

endmodule

// File: doc/mult_minmax_seq.md
Name: mult_minmax_seq

Overview:
- Parametrised successor to the single-pair multiply-and-min unit.
- Multiplies K operand pairs sequentially with a shift-add multiplier. Each product saturates to N bits. Returns the minimum or maximum of all products and a bound operand, selected by mode.
- Sits behind a start/ready handshake. The control FSM and datapath are in one block.

Parameters:
- N, 8, operand/result width in bits (N >= 2)
- K, 4, number of operand pairs (K >= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE or DONE
- mode  input  1  0 = minimum, 1 = maximum; captured with start
- in_a  input  K*N  pair operands A; pair i at bits [i*N +: N]; captured with start
- in_b  input  K*N  pair operands B, same packing; captured with start
- in_c  input  N  bound operand; captured with start
- busy  output  1  operation in progress
- ready  output  1  result valid; held until the next accepted start
- overflow  output  1  at least one product exceeded 2^N-1 (sticky per operation)
- result  output  N  minimum or maximum of {saturated products, in_c}

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, ready=0, overflow=0, result=0; all internal registers cleared. An operation in progress is discarded.
- States: IDLE, MULT, CMP, DONE.
- IDLE/DONE with start=1 at edge t0:
  - capture in_a, in_b, in_c and mode;
  - set extreme register = in_c, pair index = 0, bit count = 0;
  - clear the 2N-bit accumulator and the overflow flag;
  - set ready=0, busy=1; go to MULT.
- MULT:
  - one shift-add step per edge, LSB-first over B: if the current B bit is 1, add (A << step) into the 2N-bit accumulator;
  - after N steps go to CMP.
- CMP (1 edge):
  - sat = (acc[2N-1:N] != 0) ? all-ones : acc[N-1:0];
  - overflow |= (acc[2N-1:N] != 0);
  - extreme = mode ? max(extreme, sat) : min(extreme, sat), unsigned;
  - if index == K-1: result = updated extreme, ready=1, busy=0, go to DONE;
  - else: index++, clear acc and bit count, go to MULT.
- Latency: each pair takes exactly N+1 edges. ready, result and overflow update at edge t0 + K*(N+1) and remain stable in DONE.
- start while busy=1 is ignored. Input changes after t0 have no effect.
- start in DONE starts a new operation: ready drops at that edge; result holds its old value until the new completion.
- Arithmetic: all values unsigned. A zero operand gives product 0, which wins in min mode.
- Ties: the extreme value is the same whichever operand wins; no index is reported.
- K=1 is legal: latency N+1.

Decomposition:
- Package mult_minmax_pkg: state enum (IDLE, MULT, CMP, DONE) and the MODE_MIN=0 / MODE_MAX=1 constants.
- One natural sub-module, shift_add_mult #(N): captured A/B, 2N-bit accumulator, step counter, and a done pulse after N steps.
- The FSM, saturation/compare logic, pair index and output registers stay in mult_minmax_seq.

Test Plan:
- N=8, K=4; A=(3,5,10,2), B=(4,6,7,9), C=50, mode=0 -> products 12,30,70,18; result=12, overflow=0; ready rises exactly 36 edges after start.
- Same operands with mode=1 -> result=70, overflow=0. Same operands with C=200, mode=1 -> result=200.
- A0=20, B0=20 (product 400), other pairs as above, C=10: mode=1 -> result=255, overflow=1; mode=0 -> result=10, overflow=1.
- start pulsed again at edge t0+5 with different operands -> ignored; result matches the first operand set.
- Assert reset asynchronously mid-MULT -> busy, ready, overflow and result are 0 immediately without waiting for a clock edge; the next start completes normally in 36 edges.
- Back-to-back: start in DONE with A0=0 -> ready falls at that edge; mode=0 gives result=0. Also check K=1 with A=255, B=255 -> result=255, overflow=1, latency 9 edges.
